// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_ctrl                                                           |
// | Run-control sequencer: button edges -> run/prog/clear, expiry beep and   |
// | one-cycle leaderboard result records.                                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TIME_W      = 39,
  parameter int BEEP_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              startstop,
  input  logic              clear,
  input  logic              prog,
  input  logic              up,
  input  logic              zero,
  input  logic [TIME_W-1:0] time_in,
  output logic              run,
  output logic              prog_en,
  output logic              sw_clear,
  output logic              rec_valid,
  output logic [TIME_W-1:0] rec_time,
  output logic              rec_up,
  output logic              beep,
  output logic [2:0]        state
);

  localparam int              CNT_W       = $clog2(BEEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_BEEP_LOAD = CNT_W'(BEEP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ss_prev;
  logic              r_clr_prev;
  logic              r_mode_up;
  logic              r_sw_clear;
  logic              r_rec_valid;
  logic [TIME_W-1:0] r_rec_time;
  logic              r_rec_up;
  logic [CNT_W-1:0]  r_beep_cnt;

  logic w_ss_edge;
  logic w_clr_edge;
  logic w_sw_clear;
  logic w_capture;
  logic w_cap_up;
  logic w_beep_load;
  logic w_beep_kill;
  logic w_mode_load;

  assign w_ss_edge  = startstop & ~r_ss_prev;
  assign w_clr_edge = clear & ~r_clr_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_sw_clear  = 1'b0;
    w_capture   = 1'b0;
    w_cap_up    = 1'b0;
    w_beep_load = 1'b0;
    w_beep_kill = 1'b0;
    w_mode_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clr_edge) w_sw_clear = 1'b1;
        if (prog) begin
          w_state_nxt = S_PROG;
        end else if (w_ss_edge && !(!up && zero)) begin
          // a count-down start from zero would expire immediately, so refuse it
          w_state_nxt = S_RUN;
          w_mode_load = 1'b1;
        end
      end
      S_PROG: begin
        if (!prog) w_state_nxt = S_IDLE;
        if (w_clr_edge) w_sw_clear = 1'b1;
      end
      S_RUN: begin
        if (!r_mode_up && zero) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
          w_cap_up    = 1'b0;
          w_beep_load = 1'b1;
        end else if (w_ss_edge) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_clr_edge) begin
          w_state_nxt = S_IDLE;
          w_sw_clear  = 1'b1;
          if (r_mode_up && !zero) begin
            w_capture = 1'b1;
            w_cap_up  = 1'b1;
          end
        end else if (w_ss_edge) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (w_clr_edge) begin
          w_state_nxt = S_IDLE;
          w_sw_clear  = 1'b1;
          w_beep_kill = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Button history resets high so a button held through reset gives no edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ss_prev   <= 1'b1;
      r_clr_prev  <= 1'b1;
      r_mode_up   <= 1'b0;
      r_sw_clear  <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec_time  <= '0;
      r_rec_up    <= 1'b0;
      r_beep_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ss_prev   <= startstop;
      r_clr_prev  <= clear;
      r_sw_clear  <= w_sw_clear;
      r_rec_valid <= w_capture;
      if (w_mode_load) r_mode_up <= up;
      if (w_capture) begin
        r_rec_time <= time_in;
        r_rec_up   <= w_cap_up;
      end
      if (w_beep_load)            r_beep_cnt <= C_BEEP_LOAD;
      else if (w_beep_kill)       r_beep_cnt <= '0;
      else if (r_beep_cnt != '0)  r_beep_cnt <= r_beep_cnt - 1'b1;
    end
  end

  assign run       = (r_state == S_RUN);
  assign prog_en   = (r_state == S_PROG);
  assign state     = r_state;
  assign sw_clear  = r_sw_clear;
  assign rec_valid = r_rec_valid;
  assign rec_time  = r_rec_time;
  assign rec_up    = r_rec_up;
  // Loaded with BEEP_CYCLES on entry, so beep is high for exactly that many cycles.
  assign beep      = (r_beep_cnt != '0);

endmodule
`default_nettype wire
